serial_parallel: RTL and testbench
==================================

# serial_parallel

Deserializer that sits directly downstream of `parallel_serial`. It collects a stream of single bits qualified by `serial_valid_i` and `clk_en_i` into `WORD_WIDTH`-bit words. Each completed word is presented on a one-entry valid/ready output register. A word that completes while the output register is still occupied is dropped and recorded in a sticky overflow flag.

## Interface
Parameters:
- `WORD_WIDTH`, default 8: bits per word; legal values are 2 and above.
- `MSB_FIRST`, default 1: 1 means the first received bit lands in `parallel_o[WORD_WIDTH-1]`; 0 means the first received bit lands in `parallel_o[0]`.

Ports:
- `clk_i`  in  1  sole clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `clk_en_i`  in  1  bit-rate enable; a bit is sampled only when high.
- `serial_valid_i`  in  1  `serial_i` carries a valid bit this cycle.
- `serial_i`  in  1  serial data bit.
- `flush_i`  in  1  discards the partially assembled word.
- `parallel_valid_o`  out  1  output register holds a word.
- `parallel_ready_i`  in  1  consumer accepts the word.
- `parallel_o`  out  WORD_WIDTH  assembled word.
- `overflow_o`  out  1  sticky flag: at least one word was dropped.

## Operation
- Bit acceptance: a bit is accepted when `clk_en_i & serial_valid_i & ~flush_i`.
- Internal state:
  - shift register `sh[WORD_WIDTH-1:0]`.
  - bit counter `cnt`, `$clog2(WORD_WIDTH)` bits, counting 0..WORD_WIDTH-1.
  - output register `out_q` plus `parallel_valid_o`.
- Shifting on an accepted bit:
  - `MSB_FIRST`=1: `sh <= {sh[WORD_WIDTH-2:0], serial_i}`.
  - `MSB_FIRST`=0: `sh <= {serial_i, sh[WORD_WIDTH-1:1]}`.
- Word completion: an accepted bit with `cnt==WORD_WIDTH-1`.
  - The completed word is the shifted value including this bit.
  - `cnt` wraps to 0.
- Output register is a two-state FSM:
  - EMPTY (`parallel_valid_o`=0): a completed word loads `out_q` and moves to FULL.
  - FULL: a pop (`parallel_valid_o & parallel_ready_i`) without a completion returns to EMPTY.
  - FULL with pop and completion in the same cycle: stays FULL and loads the new word (zero-bubble).
  - FULL with completion and no pop: the new word is dropped, `out_q` is unchanged, and `overflow_o` is set to 1.
- `overflow_o` remains 1 until `rst_i`.
- Output handshake is not gated by `clk_en_i`; pops can occur on any cycle.
- `parallel_o` is held stable while `parallel_valid_o & ~parallel_ready_i`.
- `flush_i`:
  - clears `cnt` and `sh` next edge, independent of `clk_en_i`.
  - takes priority over a coincident bit, which is discarded.
  - does not touch the output register or `overflow_o`.
- `rst_i` has priority over all inputs, including mid-word and while FULL.

## Timing
- Reset values: `parallel_valid_o`=0, `parallel_o`=0, `overflow_o`=0, `cnt`=0, `sh`=0.
- Latency: `parallel_valid_o` and the new `parallel_o` are visible in the cycle after the edge that accepts the last bit.
- Throughput: one word per WORD_WIDTH accepted bits. With `parallel_ready_i` held high, no words are lost at any bit rate, including back-to-back bits every cycle.
- Bits need not be contiguous. Gaps in `serial_valid_i` or `clk_en_i` hold `cnt` and `sh` unchanged.
- Pop timing: `parallel_valid_o` falls in the cycle after the pop edge, unless the same edge reloads the register.
- Drop timing: `overflow_o` rises in the cycle after the dropping edge.
- Reset mid-word: the partial word is lost, and the first bit after reset is bit 0 of a new word.

## Test plan
- **Basic, MSB first:** reset, then send bits 1,0,1,0,0,1,0,1 (`serial_valid_i`=`clk_en_i`=1, ready=1). Expect `parallel_o`=0xA5 with `parallel_valid_o` high for exactly one cycle, starting the cycle after the 8th bit.
- **LSB first:** with `MSB_FIRST`=0, send the same sequence. Expect `parallel_o`=0xA5 reversed, i.e. 0xA5 (palindrome check). Then send 1,0,0,0,0,0,0,0 and expect 0x01; with `MSB_FIRST`=1 the same bits give 0x80.
- **Back-pressure and overflow:**
  - Hold ready=0 and send two words, 0x3C then 0xC3. Expect `parallel_o` to stay 0x3C, `overflow_o` to rise after the 16th bit, and 0xC3 to be dropped.
  - Raise ready for one cycle: expect one pop, then `parallel_valid_o`=0 with `overflow_o` still 1.
- **Simultaneous pop and completion:** with ready=1 continuously, stream 0x11 then 0x22 back-to-back with every-cycle bits. Expect `parallel_valid_o` on both words, 0x22 appearing exactly 8 cycles after 0x11, and `overflow_o`=0.
- **Enable gaps and flush:**
  - Toggle `clk_en_i` 1/0 every cycle while sending 0xF0. Expect 0xF0 after 8 enabled bits.
  - Send 3 bits of 0xFF, assert `flush_i` together with a valid bit, then send 0x0F. Expect 0x0F only.
- **Reset mid-operation:** assert `rst_i` for one cycle after 5 bits while the output register holds 0x55 and `overflow_o`=1. Expect all outputs to be 0 the next cycle, and the following 8 bits 0x81 to produce 0x81.

Source files
------------

// File: rtl/serial_parallel.sv
// serial_parallel: deserializer that packs qualified serial bits into WORD_WIDTH-bit
// words and presents each word on a one-entry valid/ready output register.
// A word that completes while the register is full and not being popped is
// dropped, and the drop sets a sticky overflow flag.
//
// Ports:
//   clk_i            clock, rising edge
//   rst_i            synchronous active-high reset
//   clk_en_i         bit-rate enable; bits are sampled only while high
//   serial_valid_i   serial_i carries a valid bit
//   serial_i         serial data bit
//   flush_i          discards the partially assembled word
//   parallel_valid_o output register holds a word
//   parallel_ready_i consumer accepts the word
//   parallel_o       assembled word
//   overflow_o       sticky: at least one word was dropped
module serial_parallel #(
    parameter int unsigned WORD_WIDTH = 8,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clk_en_i,
    input  logic                  serial_valid_i,
    input  logic                  serial_i,
    input  logic                  flush_i,
    output logic                  parallel_valid_o,
    input  logic                  parallel_ready_i,
    output logic [WORD_WIDTH-1:0] parallel_o,
    output logic                  overflow_o
);

    localparam int unsigned CNT_W = $clog2(WORD_WIDTH);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                state_q;
    logic [WORD_WIDTH-1:0] sh_q;
    logic [CNT_W-1:0]      cnt_q;

    logic                  bit_acc_c;
    logic                  word_done_c;
    logic                  pop_c;
    logic [WORD_WIDTH-1:0] sh_next_c;

    // Bit qualification, word completion and pop detection
    always_comb begin
        bit_acc_c   = clk_en_i & serial_valid_i & ~flush_i;
        word_done_c = bit_acc_c & (cnt_q == CNT_W'(WORD_WIDTH - 1));
        pop_c       = parallel_valid_o & parallel_ready_i;
        if (MSB_FIRST) begin
            sh_next_c = {sh_q[WORD_WIDTH-2:0], serial_i};
        end else begin
            sh_next_c = {serial_i, sh_q[WORD_WIDTH-1:1]};
        end
    end

    // Shift register / bit counter, plus the output register FSM
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sh_q             <= '0;
            cnt_q            <= '0;
            state_q          <= EMPTY;
            parallel_valid_o <= 1'b0;
            parallel_o       <= '0;
            overflow_o       <= 1'b0;
        end else begin
            // Flush wins over a coincident bit and ignores the enable
            if (flush_i) begin
                sh_q  <= '0;
                cnt_q <= '0;
            end else if (bit_acc_c) begin
                sh_q  <= sh_next_c;
                cnt_q <= word_done_c ? '0 : cnt_q + CNT_W'(1);
            end

            case (state_q)
                EMPTY: begin
                    if (word_done_c) begin
                        parallel_o       <= sh_next_c;
                        parallel_valid_o <= 1'b1;
                        state_q          <= FULL;
                    end
                end
                FULL: begin
                    if (word_done_c && pop_c) begin
                        // Zero-bubble reload: old word leaves as the new one arrives
                        parallel_o <= sh_next_c;
                    end else if (word_done_c) begin
                        // Register still occupied: drop the new word
                        overflow_o <= 1'b1;
                    end else if (pop_c) begin
                        parallel_valid_o <= 1'b0;
                        state_q          <= EMPTY;
                    end
                end
                default: begin
                    state_q          <= EMPTY;
                    parallel_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_parallel.sv
// tb_serial_parallel: drives an MSB-first and an LSB-first instance with the same
// bit stream and checks both every cycle against a queue-based word model,
// plus directed scenarios with hand-computed expected words.
module tb_serial_parallel;

    localparam int unsigned W = 8;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic         rst_i, clk_en_i, serial_valid_i, serial_i, flush_i, parallel_ready_i;
    logic         pv_m, pv_l, ov_m, ov_l;
    logic [W-1:0] pd_m, pd_l;

    int errors = 0;
    int checks = 0;

    serial_parallel #(.WORD_WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk_i(clk_i), .rst_i(rst_i), .clk_en_i(clk_en_i),
        .serial_valid_i(serial_valid_i), .serial_i(serial_i), .flush_i(flush_i),
        .parallel_valid_o(pv_m), .parallel_ready_i(parallel_ready_i),
        .parallel_o(pd_m), .overflow_o(ov_m)
    );

    serial_parallel #(.WORD_WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk_i(clk_i), .rst_i(rst_i), .clk_en_i(clk_en_i),
        .serial_valid_i(serial_valid_i), .serial_i(serial_i), .flush_i(flush_i),
        .parallel_valid_o(pv_l), .parallel_ready_i(parallel_ready_i),
        .parallel_o(pd_l), .overflow_o(ov_l)
    );

    // Reference model: bits of the word in progress, in arrival order
    logic         mq[$];
    logic         m_valid = 1'b0;
    logic         m_ovf   = 1'b0;
    logic [W-1:0] m_msb   = '0;
    logic [W-1:0] m_lsb   = '0;
    bit           live    = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk_i) begin
        logic         done;
        logic         pop;
        logic [W-1:0] w_msb;
        logic [W-1:0] w_lsb;
        if (rst_i) begin
            mq.delete();
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_msb   = '0;
            m_lsb   = '0;
            live    = 1'b1;
        end else if (live) begin
            done  = 1'b0;
            pop   = m_valid & parallel_ready_i;
            w_msb = '0;
            w_lsb = '0;
            if (flush_i) begin
                mq.delete();
            end else if (clk_en_i && serial_valid_i) begin
                mq.push_back(serial_i);
                if (mq.size() == W) begin
                    for (int i = 0; i < W; i++) begin
                        w_msb[W-1-i] = mq[i];
                        w_lsb[i]     = mq[i];
                    end
                    mq.delete();
                    done = 1'b1;
                end
            end
            if (done) begin
                if (!m_valid || pop) begin
                    m_valid = 1'b1;
                    m_msb   = w_msb;
                    m_lsb   = w_lsb;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (pop) begin
                m_valid = 1'b0;
            end
        end
    end

    // Per-cycle compare, away from the active edge
    always @(negedge clk_i) begin
        if (live) begin
            check("valid_msb", W'(pv_m), W'(m_valid));
            check("valid_lsb", W'(pv_l), W'(m_valid));
            check("ovf_msb", W'(ov_m), W'(m_ovf));
            check("ovf_lsb", W'(ov_l), W'(m_ovf));
            if (m_valid) begin
                check("data_msb", pd_m, m_msb);
                check("data_lsb", pd_l, m_lsb);
            end
        end
    end

    task automatic cyc(input logic en, input logic v, input logic b, input logic fl,
                       input logic rdy, input logic rst);
        clk_en_i         = en;
        serial_valid_i   = v;
        serial_i         = b;
        flush_i          = fl;
        parallel_ready_i = rdy;
        rst_i            = rst;
        @(negedge clk_i);
        #1;
    endtask

    task automatic send(input logic [7:0] w, input logic rdy);
        for (int i = 7; i >= 0; i--) cyc(1'b1, 1'b1, w[i], 1'b0, rdy, 1'b0);
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    initial begin
        logic [7:0] f0;
        f0 = 8'hF0;
        rst_i = 1'b1; clk_en_i = 1'b0; serial_valid_i = 1'b0; serial_i = 1'b0;
        flush_i = 1'b0; parallel_ready_i = 1'b0;
        @(negedge clk_i);
        #1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Reset values
        check("rst_valid", W'(pv_m), '0);
        check("rst_data", pd_m, '0);
        check("rst_ovf", W'(ov_m), '0);

        // Basic word: palindrome in both bit orders
        send(8'hA5, 1'b1);
        check("a5_valid", W'(pv_m), W'(1));
        check("a5_msb", pd_m, 8'hA5);
        check("a5_lsb", pd_l, 8'hA5);
        idle(1'b1);
        check("a5_one_cycle", W'(pv_m), '0);

        // Bit-order distinction
        send(8'h80, 1'b1);
        check("first_bit_msb", pd_m, 8'h80);
        check("first_bit_lsb", pd_l, 8'h01);
        idle(1'b1);

        // Back-pressure: second word dropped, overflow sticks
        send(8'h3C, 1'b0);
        check("bp_first", pd_m, 8'h3C);
        send(8'hC3, 1'b0);
        check("bp_held", pd_m, 8'h3C);
        check("bp_ovf", W'(ov_m), W'(1));
        idle(1'b1);
        check("bp_popped", W'(pv_m), '0);
        check("bp_ovf_sticky", W'(ov_m), W'(1));
        idle(1'b0);

        // Zero-bubble: back-to-back words with ready held high
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        send(8'h11, 1'b1);
        check("b2b_first", pd_m, 8'h11);
        send(8'h22, 1'b1);
        check("b2b_second", pd_m, 8'h22);
        check("b2b_valid", W'(pv_m), W'(1));
        check("b2b_no_ovf", W'(ov_m), '0);
        idle(1'b1);

        // Enable toggling every cycle, with junk bits on disabled cycles
        for (int i = 7; i >= 0; i--) begin
            cyc(1'b1, 1'b1, f0[i], 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b1, ~f0[i], 1'b0, 1'b0, 1'b0);
        end
        check("en_gap_msb", pd_m, 8'hF0);
        check("en_gap_lsb", pd_l, 8'h0F);
        idle(1'b1);

        // Flush discards partial word and its coincident bit
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        send(8'h0F, 1'b0);
        check("flush_msb", pd_m, 8'h0F);
        check("flush_lsb", pd_l, 8'hF0);
        idle(1'b1);

        // Reset mid-word while full and overflowed
        send(8'h55, 1'b0);
        send(8'hAA, 1'b0);
        check("pre_rst_data", pd_m, 8'h55);
        check("pre_rst_ovf", W'(ov_m), W'(1));
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("mid_rst_valid", W'(pv_m), '0);
        check("mid_rst_data", pd_m, '0);
        check("mid_rst_ovf", W'(ov_m), '0);
        send(8'h81, 1'b1);
        check("post_rst_msb", pd_m, 8'h81);
        check("post_rst_lsb", pd_l, 8'h81);
        idle(1'b1);

        // Randomized traffic, checked by the per-cycle compare
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 1) != 0, $urandom_range(0, 31) == 0,
                $urandom_range(0, 2) != 0, $urandom_range(0, 499) == 0);
        end
        idle(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
